siso_alpha_recursion: RTL and testbench



---
 rtl/siso_pkg.sv | 33 +++
 rtl/siso_alpha_recursion_if.sv | 19 +
 rtl/siso_acs.sv | 16 +
 rtl/siso_alpha_recursion.sv | 67 ++++++
 tb/tb_siso_alpha_recursion.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/siso_pkg.sv
// siso_pkg: shared types, trellis tables and saturating arithmetic for the alpha recursion.
// Holds metric width W, state count, initial metric, the per-state predecessor and
// branch-metric selection tables, and saturating add/sub/negate helpers.
package siso_pkg;
   localparam int W          = 16;
   localparam int NUM_STATES = 8;
   typedef logic signed [W-1:0] metric_t;
   localparam metric_t M_MIN    = {1'b1, {(W-1){1'b0}}};
   localparam metric_t M_MAX    = ~M_MIN;
   localparam metric_t NEG_INIT = metric_t'(-(2**(W-2)));
   typedef enum logic {IDLE, RUN} state_t;
   // Branch metric choice: +G1, -G1, +G2, -G2 (index into the signed gamma set)
   typedef enum logic [1:0] {G_P1, G_N1, G_P2, G_N2} gsel_t;
   localparam logic [2:0] PRED [NUM_STATES][2] = '{
      '{3'd0, 3'd1}, '{3'd2, 3'd3}, '{3'd4, 3'd5}, '{3'd6, 3'd7},
      '{3'd0, 3'd1}, '{3'd2, 3'd3}, '{3'd4, 3'd5}, '{3'd6, 3'd7}};
   localparam gsel_t GSEL [NUM_STATES][2] = '{
      '{G_P1, G_N1}, '{G_N2, G_P2}, '{G_P2, G_N2}, '{G_N1, G_P1},
      '{G_N1, G_P1}, '{G_P2, G_N2}, '{G_N2, G_P2}, '{G_P1, G_N1}};
   // One guard bit is enough: overflow shows as the top two bits disagreeing
   function automatic metric_t sat_w(input logic signed [W:0] x);
      return (x[W] != x[W-1]) ? (x[W] ? M_MIN : M_MAX) : x[W-1:0];
   endfunction
   function automatic metric_t sat_add(input metric_t a, input metric_t b);
      return sat_w({a[W-1], a} + {b[W-1], b});
   endfunction
   function automatic metric_t sat_sub(input metric_t a, input metric_t b);
      return sat_w({a[W-1], a} - {b[W-1], b});
   endfunction
   function automatic metric_t sat_neg(input metric_t a);
      return (a == M_MIN) ? M_MAX : -a;
   endfunction
endpackage

// File: rtl/siso_alpha_recursion_if.sv
// siso_alpha_recursion_if: gamma input and alpha output bundle of the alpha recursion.
// master drives gamma1/gamma2/gamma_valid/blklen; slave (the recursion) drives
// alpha_out/alpha_valid/alpha_last/step_idx/busy/err_len.
interface siso_alpha_recursion_if;
   logic signed [siso_pkg::W-1:0]               gamma1;
   logic signed [siso_pkg::W-1:0]               gamma2;
   logic                                        gamma_valid;
   logic [15:0]                                 blklen;
   logic [siso_pkg::NUM_STATES*siso_pkg::W-1:0] alpha_out;
   logic                                        alpha_valid;
   logic                                        alpha_last;
   logic [15:0]                                 step_idx;
   logic                                        busy;
   logic                                        err_len;
   modport master (output gamma1, gamma2, gamma_valid, blklen,
                   input  alpha_out, alpha_valid, alpha_last, step_idx, busy, err_len);
   modport slave  (input  gamma1, gamma2, gamma_valid, blklen,
                   output alpha_out, alpha_valid, alpha_last, step_idx, busy, err_len);
endinterface

// File: rtl/siso_acs.sv
// siso_acs: max-log add-compare-select for one next state.
// a0/a1: predecessor metrics, g0/g1: their signed branch metrics, a_new: survivor metric.
module siso_acs
   import siso_pkg::*;
(
   input  metric_t a0,
   input  metric_t a1,
   input  metric_t g0,
   input  metric_t g1,
   output metric_t a_new
);
   metric_t m0, m1;
   assign m0    = sat_add(a0, g0);
   assign m1    = sat_add(a1, g1);
   assign a_new = (m1 > m0) ? m1 : m0;
endmodule

// File: rtl/siso_alpha_recursion.sv
// siso_alpha_recursion: forward alpha recursion over the 8-state LTE RSC trellis.
// clk/rst: clock and sync active-high reset; bus: gamma inputs and normalized alpha
// stream with valid/last/step index, busy flag and zero-length error pulse.
module siso_alpha_recursion
   import siso_pkg::*;
(
   input logic                    clk,
   input logic                    rst,
   siso_alpha_recursion_if.slave  bus
);
   state_t      state, state_n;
   metric_t     alpha    [NUM_STATES];
   metric_t     acs_out  [NUM_STATES];
   metric_t     alpha_nx [NUM_STATES];
   metric_t     gv       [4];
   logic [15:0] k, len;
   logic        step, last;
   assign gv[G_P1] = bus.gamma1;
   assign gv[G_N1] = sat_neg(bus.gamma1);
   assign gv[G_P2] = bus.gamma2;
   assign gv[G_N2] = sat_neg(bus.gamma2);
   for (genvar i = 0; i < NUM_STATES; i++) begin : g_acs
      siso_acs u_acs (
         .a0   (alpha[PRED[i][0]]),
         .a1   (alpha[PRED[i][1]]),
         .g0   (gv[GSEL[i][0]]),
         .g1   (gv[GSEL[i][1]]),
         .a_new(acs_out[i])
      );
      assign alpha_nx[i] = sat_sub(acs_out[i], acs_out[0]);
   end
   // In IDLE the length has not been latched yet, so the last-step test uses blklen directly
   always_comb begin
      step    = bus.gamma_valid && (state == RUN || bus.blklen != 16'd0);
      last    = step && ((state == IDLE) ? (bus.blklen == 16'd1) : (k == len - 16'd1));
      state_n = last ? IDLE : (step ? RUN : state);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         k               <= '0;
         len             <= '0;
         bus.alpha_out   <= '0;
         bus.alpha_valid <= 1'b0;
         bus.alpha_last  <= 1'b0;
         bus.step_idx    <= '0;
         bus.busy        <= 1'b0;
         bus.err_len     <= 1'b0;
         for (int s = 0; s < NUM_STATES; s++) alpha[s] <= (s == 0) ? '0 : NEG_INIT;
      end else begin
         state           <= state_n;
         bus.alpha_valid <= step;
         bus.alpha_last  <= last;
         bus.busy        <= (state_n == RUN);
         bus.err_len     <= bus.gamma_valid && state == IDLE && bus.blklen == 16'd0;
         if (state == IDLE && step) len <= bus.blklen;
         if (step) begin
            bus.step_idx <= k;
            k            <= last ? '0 : k + 16'd1;
            for (int s = 0; s < NUM_STATES; s++) begin
               bus.alpha_out[s*W +: W] <= alpha_nx[s];
               alpha[s]                <= last ? ((s == 0) ? '0 : NEG_INIT) : alpha_nx[s];
            end
         end
      end
   end
endmodule

// File: tb/tb_siso_alpha_recursion.sv
// tb_siso_alpha_recursion: directed plus random stimulus against a trellis-level reference model.
module tb_siso_alpha_recursion;
   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;
   siso_alpha_recursion_if bus();
   siso_alpha_recursion dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // reference state
   int           m[8];
   bit           in_blk;
   int           rk, rlen;
   logic [127:0] e_out;
   logic [15:0]  e_idx;
   logic         e_valid, e_last, e_err, e_busy;
   function automatic int sat(input int x);
      return (x > 32767) ? 32767 : (x < -32768) ? -32768 : x;
   endfunction
   function automatic void m_init();
      for (int s = 0; s < 8; s++) m[s] = (s == 0) ? 0 : -16384;
   endfunction
   // Encoder-level trellis: feedback 1+D^2+D^3, parity 1+D+D^3, bit 0 -> +1
   function automatic void trellis(input int g1, input int g2, output int nx[8]);
      int best[8];
      for (int s = 0; s < 8; s++) best[s] = -1000000;
      for (int s = 0; s < 8; s++)
         for (int u = 0; u < 2; u++) begin
            int d1, d2, d3, a, p, ns, bm, v;
            d1 = (s >> 2) & 1; d2 = (s >> 1) & 1; d3 = s & 1;
            a  = u ^ d2 ^ d3;
            p  = a ^ d1 ^ d3;
            ns = 4*a + 2*d1 + d2;
            bm = (u == p) ? (u ? sat(-g1) : g1) : (u ? sat(-g2) : g2);
            v  = sat(m[s] + bm);
            if (v > best[ns]) best[ns] = v;
         end
      for (int s = 0; s < 8; s++) nx[s] = sat(best[s] - best[0]);
   endfunction
   function automatic void model(input bit r, input bit v, input int g1, input int g2, input int bl);
      int nx[8];
      e_valid = 0; e_last = 0; e_err = 0;
      if (r) begin
         in_blk = 0; rk = 0; rlen = 0; m_init(); e_out = '0; e_idx = '0;
      end else if (v) begin
         if (!in_blk && bl == 0) e_err = 1;
         else begin
            if (!in_blk) begin in_blk = 1; rlen = bl; rk = 0; end
            trellis(g1, g2, nx);
            for (int s = 0; s < 8; s++) e_out[s*16 +: 16] = 16'(nx[s]);
            e_idx   = 16'(rk);
            e_valid = 1;
            if (rk == rlen - 1) begin
               e_last = 1; in_blk = 0; rk = 0; m_init();
            end else begin
               for (int s = 0; s < 8; s++) m[s] = nx[s];
               rk++;
            end
         end
      end
      e_busy = in_blk;
   endfunction
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input bit r, input bit v, input int g1, input int g2, input int bl);
      rst             = r;
      bus.gamma_valid = v;
      bus.gamma1      = 16'(g1);
      bus.gamma2      = 16'(g2);
      bus.blklen      = 16'(bl);
      model(r, v, g1, g2, bl);
      @(posedge clk);
      #1;
      chk("alpha_valid", 128'(bus.alpha_valid), 128'(e_valid));
      chk("alpha_last",  128'(bus.alpha_last),  128'(e_last));
      chk("err_len",     128'(bus.err_len),     128'(e_err));
      chk("busy",        128'(bus.busy),        128'(e_busy));
      chk("step_idx",    128'(bus.step_idx),    128'(e_idx));
      chk("alpha_out",   bus.alpha_out,         e_out);
   endtask
   function automatic int rg();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction
   logic [127:0] init_vec;
   initial begin
      int iv[8] = '{0, -16390, -16390, -16384, -20, -16390, -16390, -16384};
      for (int s = 0; s < 8; s++) init_vec[s*16 +: 16] = 16'(iv[s]);
      // reset state
      cyc(1, 0, 0, 0, 0);
      cyc(1, 1, 5, 5, 4);
      cyc(0, 0, 0, 0, 0);
      // init step, then finish the block
      cyc(0, 1, 10, 4, 4);
      chk("init_vec", bus.alpha_out, init_vec);
      for (int i = 0; i < 3; i++) cyc(0, 1, rg(), rg(), 4);
      cyc(0, 0, 0, 0, 0);
      // all-zero codeword, then immediate next block
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 100, 0, 4);
         chk("zero_alpha0", 128'(bus.alpha_out[15:0]), 128'(0));
      end
      cyc(0, 1, 10, 4, 2);
      chk("restart_vec", bus.alpha_out, init_vec);
      cyc(0, 1, rg(), rg(), 2);
      // saturation
      for (int i = 0; i < 10; i++) cyc(0, 1, 32767, -32768, 10);
      cyc(0, 0, 0, 0, 0);
      // gaps and back-to-back
      cyc(0, 1, rg(), rg(), 3);
      cyc(0, 0, rg(), rg(), 3);
      cyc(0, 0, rg(), rg(), 3);
      cyc(0, 1, rg(), rg(), 3);
      cyc(0, 1, rg(), rg(), 3);
      cyc(0, 1, rg(), rg(), 3);
      cyc(0, 1, rg(), rg(), 5);
      cyc(0, 1, rg(), rg(), 9);
      cyc(0, 0, 0, 0, 0);
      // zero length then single step
      cyc(0, 1, 7, 7, 0);
      cyc(0, 1, 10, 4, 1);
      chk("len1_vec", bus.alpha_out, init_vec);
      cyc(0, 0, 0, 0, 0);
      // reset mid-block
      cyc(0, 1, rg(), rg(), 8);
      cyc(0, 1, rg(), rg(), 8);
      cyc(1, 1, rg(), rg(), 8);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 10, 4, 4);
      chk("post_rst_vec", bus.alpha_out, init_vec);
      for (int i = 0; i < 3; i++) cyc(0, 1, rg(), rg(), 4);
      // random blocks with gaps and blklen wobble
      for (int i = 0; i < 400; i++)
         cyc(0, ($urandom_range(0, 3) != 0), rg(), rg(), int'($urandom_range(0, 6)));
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
